// File: rtl/logger_demo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : logger_demo_pkg
//  Purpose  : Shared types and constants for the logger demo event source.
//             demo_ev_t is sized to the largest supported field widths; the
//             top-level slices it down to its configured widths.
//  Revision : 1.0 - initial release
// ============================================================================
package logger_demo_pkg;

  localparam int MAX_ID_W = 32;   // widest supported event ID
  localparam int MAX_TS_W = 64;   // widest supported timestamp
  localparam int MAX_CH_W = 4;    // enough for 16 channels

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_TS_W-1:0] start_ts;
    logic [MAX_TS_W-1:0] end_ts;
    logic [MAX_TS_W-1:0] delta;
  } demo_ev_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/logger_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : logger_rr_arb
//  Purpose  : Round-robin arbiter. Grants the first requester at or after the
//             rotating pointer; the pointer moves past the winner only when
//             the caller accepts the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module logger_rr_arb #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i_req,
  input  logic              i_accept,
  output logic [N_CH-1:0]   o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_any
);

  logic [IDX_W-1:0] r_ptr;
  logic [N_CH-1:0]  w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  // Search requesters starting at the pointer, wrapping modulo N_CH.
  always_comb begin
    int j;
    j       = 0;
    w_grant = '0;
    w_idx   = '0;
    w_any   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      j = int'(r_ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!w_any && i_req[j]) begin
        w_any      = 1'b1;
        w_grant[j] = 1'b1;
        w_idx      = IDX_W'(j);
      end
    end
  end

  // Advance the pointer to one past the accepted winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_accept && w_any) begin
      r_ptr <= (w_idx == IDX_W'(N_CH - 1)) ? '0 : w_idx + 1'b1;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_any       = w_any;

endmodule
`default_nettype wire

// File: rtl/logger_demo_ev_gen.sv
`default_nettype none
// ============================================================================
//  Module   : logger_demo_ev_gen
//  Purpose  : Multi-channel demo event source. N_CH staggered periodic timers
//             raise pending events, a round-robin arbiter merges them into a
//             valid/ready stream carrying ID, channel and timestamps.
//  Config   : LOGGER_DEMO_EV_DROP_CNT_EN - build the saturating drop counter;
//             when undefined drop_cnt reads 0 (older event is still kept).
//  Limits   : N_CH 1..16, ID_W <= 32, TS_W <= 64, PERIOD_CYCLES >= N_CH+2.
//  Revision : 1.0 - initial release
// ============================================================================
module logger_demo_ev_gen
  import logger_demo_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int ID_W          = 16,
  parameter int TS_W          = 64,
  parameter int PERIOD_CYCLES = 50_000_000,
  parameter int DELTA_BASE    = 1000,
  parameter int DROP_W        = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   rand_mode,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [ID_W-1:0]                        out_id,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch,
  output logic [TS_W-1:0]                        out_start_ts,
  output logic [TS_W-1:0]                        out_end_ts,
  output logic [TS_W-1:0]                        out_delta,
  output logic [DROP_W-1:0]                      drop_cnt
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2(PERIOD_CYCLES + N_CH) + 1;

  logic [TS_W-1:0]  r_cnt;
  logic [TMR_W-1:0] r_tmr   [N_CH];
  logic [TS_W-1:0]  r_start [N_CH];
  logic [N_CH-1:0]  r_pend;
  logic [N_CH-1:0]  w_fire;
  logic [N_CH-1:0]  w_take;
  logic [N_CH-1:0]  w_grant;
  logic [CH_W-1:0]  w_grant_idx;
  logic             w_any;
  logic             w_load;
  logic [TS_W-1:0]  w_start_sel;
  logic [TS_W-1:0]  w_delta;
  logic [TS_W-1:0]  w_end;
  logic [ID_W-1:0]  w_next_id;
  logic [ID_W-1:0]  r_id_cnt;
  logic [15:0]      r_lfsr;
  logic             r_valid;
  demo_ev_t         r_ev;
  logic             w_unused_ev;

  // Free-running timestamp counter, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 1'b1;
  end

  // A channel fires in the cycle its timer sits at zero while enabled.
  always_comb begin
    w_fire = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_fire[i] = en && (r_tmr[i] == '0);
    end
  end

  // Per-channel down-counters, staggered by one cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) r_tmr[i] <= TMR_W'(PERIOD_CYCLES - 1 + i);
    end else if (en) begin
      for (int i = 0; i < N_CH; i++) begin
        r_tmr[i] <= w_fire[i] ? TMR_W'(PERIOD_CYCLES - 1) : r_tmr[i] - 1'b1;
      end
    end
  end

  logger_rr_arb #(
    .N_CH  (N_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (r_pend),
    .i_accept    (w_load),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any       (w_any)
  );

  assign w_load = (!r_valid || out_ready) && w_any;
  assign w_take = w_load ? w_grant : '0;

  // Pending flags and start snapshots; a grant frees the slot for a
  // same-cycle fire, otherwise a fire on a full slot is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      for (int i = 0; i < N_CH; i++) r_start[i] <= '0;
    end else begin
      r_pend <= (r_pend & ~w_take) | w_fire;
      for (int i = 0; i < N_CH; i++) begin
        if (w_fire[i] && (!r_pend[i] || w_take[i])) r_start[i] <= r_cnt;
      end
    end
  end

  // Start timestamp of the granted channel.
  always_comb begin
    w_start_sel = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (w_grant[i]) w_start_sel = r_start[i];
    end
  end

  assign w_delta   = rand_mode ? (TS_W'(DELTA_BASE) + TS_W'(r_lfsr[7:0]))
                               : TS_W'(DELTA_BASE);
  assign w_end     = w_start_sel + w_delta;
  assign w_next_id = r_id_cnt + 1'b1;

  // Output register: loads a new event when empty or being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_ev     <= '0;
      r_id_cnt <= '0;
      r_lfsr   <= LFSR_SEED;
    end else if (w_load) begin
      r_valid     <= 1'b1;
      r_id_cnt    <= w_next_id;
      r_ev.id     <= MAX_ID_W'(w_next_id);
      r_ev.ch     <= MAX_CH_W'(w_grant_idx);
      r_ev.start_ts <= MAX_TS_W'(w_start_sel);
      r_ev.end_ts <= MAX_TS_W'(w_end);
      r_ev.delta  <= MAX_TS_W'(w_delta);
      if (rand_mode) r_lfsr <= lfsr_next(r_lfsr);
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_id       = r_ev.id[ID_W-1:0];
  assign out_ch       = r_ev.ch[CH_W-1:0];
  assign out_start_ts = r_ev.start_ts[TS_W-1:0];
  assign out_end_ts   = r_ev.end_ts[TS_W-1:0];
  assign out_delta    = r_ev.delta[TS_W-1:0];

  // Struct bits above the configured widths are always zero; fold them
  // into one sink so they are not left dangling.
  assign w_unused_ev = ^r_ev;

`ifdef LOGGER_DEMO_EV_DROP_CNT_EN
  logic [N_CH-1:0]   w_drop;
  logic [DROP_W-1:0] w_drop_nxt;
  logic [DROP_W-1:0] r_drop_cnt;

  assign w_drop = w_fire & r_pend & ~w_take;

  // Add one per dropped channel, clamping at all-ones.
  always_comb begin
    w_drop_nxt = r_drop_cnt;
    for (int i = 0; i < N_CH; i++) begin
      if (w_drop[i] && (w_drop_nxt != '1)) w_drop_nxt = w_drop_nxt + 1'b1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_drop_cnt <= '0;
    else     r_drop_cnt <= w_drop_nxt;
  end

  assign drop_cnt = r_drop_cnt;
`else
  assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logger_demo_ev_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_logger_demo_ev_gen
//  Purpose  : Directed self-checking bench for logger_demo_ev_gen.
//             u_dut: N_CH=2, PERIOD=10, 64-bit timestamps.
//             u_dut_w: narrow ID/TS widths to exercise wrap-around.
//  Config   : LOGGER_DEMO_EV_DROP_CNT_EN selects the expected drop count.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_logger_demo_ev_gen;

`ifdef LOGGER_DEMO_EV_DROP_CNT_EN
  localparam int EXP_DROP = 3;
`else
  localparam int EXP_DROP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        rand_mode = 1'b0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [15:0] out_id;
  logic [0:0]  out_ch;
  logic [63:0] out_start_ts, out_end_ts, out_delta;
  logic [15:0] drop_cnt;

  logic        rst_w = 1'b1;
  logic        en_w = 1'b1;
  logic        rand_w = 1'b0;
  logic        ready_w = 1'b1;
  logic        valid_w;
  logic [1:0]  id_w;
  logic [0:0]  ch_w;
  logic [10:0] start_w, end_w, delta_w;
  logic [15:0] drop_w;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  logger_demo_ev_gen #(
    .N_CH(2), .ID_W(16), .TS_W(64), .PERIOD_CYCLES(10), .DELTA_BASE(1000), .DROP_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .en(en), .rand_mode(rand_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_ch(out_ch),
    .out_start_ts(out_start_ts), .out_end_ts(out_end_ts), .out_delta(out_delta),
    .drop_cnt(drop_cnt)
  );

  logger_demo_ev_gen #(
    .N_CH(2), .ID_W(2), .TS_W(11), .PERIOD_CYCLES(10), .DELTA_BASE(1000), .DROP_W(16)
  ) u_dut_w (
    .clk(clk), .rst(rst_w), .en(en_w), .rand_mode(rand_w),
    .out_valid(valid_w), .out_ready(ready_w), .out_id(id_w), .out_ch(ch_w),
    .out_start_ts(start_w), .out_end_ts(end_w), .out_delta(delta_w),
    .drop_cnt(drop_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reset pulse; returns at the negedge where rst was released.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Wait (bounded) for a transfer on u_dut and return its fields.
  task automatic get_ev(output logic [63:0] id, output logic [63:0] ch,
                        output logic [63:0] st, output logic [63:0] et,
                        output logic [63:0] dl);
    bit ok;
    ok = 1'b0; id = '0; ch = '0; st = '0; et = '0; dl = '0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid && out_ready) begin
        id = 64'(out_id); ch = 64'(out_ch); st = out_start_ts;
        et = out_end_ts;  dl = out_delta;   ok = 1'b1;
        break;
      end
      @(posedge clk); @(negedge clk);
    end
    if (ok) begin @(posedge clk); @(negedge clk); end
    check("ev_arrived", 64'(ok), 64'd1);
  endtask

  logic [63:0] id, ch, st, et, dl;
  int          lat, nxf;
  logic [63:0] exp_dl [4] = '{64'd1225, 64'd1112, 64'd1056, 64'd1156};
  logic [63:0] exp_st [4] = '{64'd9, 64'd10, 64'd19, 64'd20};

  initial begin
    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_id",    64'(out_id),    64'd0);
    check("rst_ch",    64'(out_ch),    64'd0);
    check("rst_start", out_start_ts,   64'd0);
    check("rst_end",   out_end_ts,     64'd0);
    check("rst_delta", out_delta,      64'd0);
    check("rst_drop",  64'(drop_cnt),  64'd0);

    // ---------------- fixed delta, ready=1 ----------------
    rand_mode = 1'b0; out_ready = 1'b1; en = 1'b1;
    do_reset();
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin lat = i; break; end
    end
    check("t1_latency", 64'(lat), 64'd11);
    get_ev(id, ch, st, et, dl);
    check("t1_e1_id", id, 64'd1);     check("t1_e1_ch", ch, 64'd0);
    check("t1_e1_st", st, 64'd9);     check("t1_e1_end", et, 64'd1009);
    check("t1_e1_dl", dl, 64'd1000);
    get_ev(id, ch, st, et, dl);
    check("t1_e2_id", id, 64'd2);     check("t1_e2_ch", ch, 64'd1);
    check("t1_e2_st", st, 64'd10);    check("t1_e2_end", et, 64'd1010);
    get_ev(id, ch, st, et, dl);
    check("t1_e3_id", id, 64'd3);     check("t1_e3_ch", ch, 64'd0);
    check("t1_e3_st", st, 64'd19);
    get_ev(id, ch, st, et, dl);
    check("t1_e4_ch", ch, 64'd1);     check("t1_e4_st", st, 64'd20);

    // ---------------- backpressure and drops ----------------
    out_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk); @(negedge clk);
      if (i >= 11) begin
        check("t2_hold_valid", 64'(out_valid), 64'd1);
        check("t2_hold_id",    64'(out_id),    64'd1);
        check("t2_hold_st",    out_start_ts,   64'd9);
      end
    end
    check("t2_hold_ch", 64'(out_ch), 64'd0);
    check("t2_drop",    64'(drop_cnt), 64'(EXP_DROP));
    out_ready = 1'b1;
    get_ev(id, ch, st, et, dl);
    check("t2_e1_id", id, 64'd1);  check("t2_e1_st", st, 64'd9);
    get_ev(id, ch, st, et, dl);
    check("t2_e2_id", id, 64'd2);  check("t2_e2_ch", ch, 64'd1);  check("t2_e2_st", st, 64'd10);
    get_ev(id, ch, st, et, dl);
    check("t2_e3_id", id, 64'd3);  check("t2_e3_ch", ch, 64'd0);  check("t2_e3_st", st, 64'd19);

    // ---------------- random delta ----------------
    rand_mode = 1'b1; out_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      get_ev(id, ch, st, et, dl);
      check("t3_delta", dl, exp_dl[k]);
      check("t3_span",  et - st, exp_dl[k]);
      check("t3_start", st, exp_st[k]);
    end
    rand_mode = 1'b0;

    // ---------------- en freeze ----------------
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    nxf = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid && out_ready) begin
        nxf++;
        check("t4_drain_id", 64'(out_id), 64'd1);
        check("t4_drain_st", out_start_ts, 64'd9);
      end
    end
    check("t4_frozen_xfers", 64'(nxf), 64'd1);
    en = 1'b1;
    get_ev(id, ch, st, et, dl);
    check("t4_e2_id", id, 64'd2);  check("t4_e2_ch", ch, 64'd1);  check("t4_e2_st", st, 64'd60);
    get_ev(id, ch, st, et, dl);
    check("t4_e3_id", id, 64'd3);  check("t4_e3_ch", ch, 64'd0);  check("t4_e3_st", st, 64'd69);

    // ---------------- async reset mid-event ----------------
    out_ready = 1'b0;
    do_reset();
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("t5_valid_before", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t5_valid_async", 64'(out_valid), 64'd0);
    check("t5_id_async",    64'(out_id),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    get_ev(id, ch, st, et, dl);
    check("t5_e1_id", id, 64'd1);  check("t5_e1_ch", ch, 64'd0);  check("t5_e1_st", st, 64'd9);

    // ---------------- ID / timestamp wrap on narrow instance ----------------
    @(negedge clk);
    rst_w = 1'b0;
    nxf = 0;
    for (int c = 0; c < 2400 && nxf < 410; c++) begin
      @(posedge clk); @(negedge clk);
      if (valid_w) begin
        int wch, wm, wst;
        nxf++;
        wch = (nxf - 1) % 2;
        wm  = (nxf - 1) / 2;
        wst = (9 + wch + 10 * wm) % 2048;
        check("t6_id",  64'(id_w),    64'(nxf % 4));
        check("t6_ch",  64'(ch_w),    64'(wch));
        check("t6_st",  64'(start_w), 64'(wst));
        check("t6_end", 64'(end_w),   64'((wst + 1000) % 2048));
      end
    end
    check("t6_count", 64'(nxf), 64'd410);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/logger_demo_ev_gen.md
Name: logger_demo_ev_gen

Overview:
Parametrised multi-channel demo event source for exercising the Logger + UART path.
- N_CH independent periodic timers, staggered by one cycle each, raise per-channel pending events.
- A round-robin arbiter merges pending events into one valid/ready output stream.
- Each event carries a global sequence ID, the source channel, and start/end/delta timestamps.
- Delta is either fixed or pseudo-random (LFSR), selected at run time; overflowed events are dropped and counted.

Parameters:
N_CH, 4, number of event channels (1..16)
ID_W, 16, width of global event ID
TS_W, 64, timestamp width
PERIOD_CYCLES, 50_000_000, per-channel event period in clocks (>= N_CH+2)
DELTA_BASE, 1000, fixed delta / random-mode base offset
DROP_W, 16, drop counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
en  in  1  timers count while high; frozen while low (pending events still drain)
rand_mode  in  1  0 = fixed delta, 1 = LFSR delta
out_valid  out  1  event valid
out_ready  in  1  consumer ready
out_id  out  ID_W  global event sequence number, first event = 1
out_ch  out  $clog2(N_CH) (min 1)  source channel
out_start_ts  out  TS_W  free-running counter snapshot at timer fire
out_end_ts  out  TS_W  start_ts + delta, mod 2^TS_W
out_delta  out  TS_W  delta
drop_cnt  out  DROP_W  events lost to overflow, saturating

Behaviour:
- Reset (async, active-high) clears everything:
  - cnt = 0.
  - Timer k = PERIOD_CYCLES-1+k.
  - All pending flags = 0; rr pointer = 0.
  - out_valid = 0; out_id/out_ch/out_*_ts/out_delta = 0.
  - drop_cnt = 0; LFSR = 16'hACE1; ID counter = 0.
  - Reset asserted mid-operation discards the in-flight output and all pending events.
- cnt: increments every clock, wraps mod 2^TS_W, unaffected by en.
- Timer k, with en high:
  - Decrements each clock.
  - When it equals 0 ("fire"), it reloads PERIOD_CYCLES-1, giving an exact period of PERIOD_CYCLES.
  - With en low, the timer holds its value.
- On fire of channel k:
  - If pending[k] = 0: set pending[k] and capture start[k] = cnt.
  - If pending[k] = 1: drop the new event, keep the older stored event, increment drop_cnt.
  - If grant of k and fire of k occur in the same cycle: the old event is granted, and the new one sets pending[k] with the new cnt. No drop.
- Output register loads when (!out_valid || out_ready) and any pending bit is set.
  - Grant goes to the first pending channel at or after rr_ptr.
  - On grant, rr_ptr = grant+1 (mod N_CH) and pending[grant] clears.
- On load:
  - out_id = id_cnt+1, and id_cnt increments. Wraps mod 2^ID_W, and 0 is allowed after the wrap.
  - out_ch = grant; out_start_ts = start[grant].
  - Delta:
    - rand_mode = 0: delta = DELTA_BASE.
    - rand_mode = 1: delta = DELTA_BASE + lfsr[7:0] (zero-extended), and the LFSR advances one step.
  - out_end_ts = out_start_ts + delta, truncated to TS_W.
- Latency: fire at edge t, pending set at edge t+1, out_valid high after edge t+2 when the output is idle.
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - Back-to-back transfers are supported (one event per clock).
  - While out_valid=1 && !out_ready, all out_* fields are held stable.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1; it never reaches 0 from the seed.
- drop_cnt saturates at all-ones.

Optional Feature:
- LOGGER_DEMO_EV_DROP_CNT_EN defined: drop_cnt counts as specified above.
- Undefined: drop_cnt is tied to 0 and the counter logic is not built; drop behaviour (older event kept) is unchanged.

Decomposition:
- Package logger_demo_pkg:
  - typedef struct demo_ev_t {id, ch, start_ts, end_ts, delta}, parametrised widths via localparams.
  - LFSR_SEED = 16'hACE1 and LFSR_TAPS = 16'hB400.
- One sub-module, logger_rr_arb: N_CH-wide request vector, rr pointer, one-hot grant + index; grant advances only on an accepted load.

Test Plan:
- Reset, N_CH=2, PERIOD_CYCLES=10, out_ready=1, rand_mode=0 -> first events {id1,ch0,start 9,end 1009,delta 1000}, {id2,ch1,start 10,end 1010}, then ch0 start 19 id3; period exactly 10.
- Same config, out_ready=0 for cycles 0..31, then 1 -> output holds id1/ch0/start 9 throughout; drop_cnt=3 (ch0@29, ch1@20, ch1@30); then id2 ch1 start 10, id3 ch0 start 19.
- rand_mode=1 -> delta sequence equals DELTA_BASE + low byte of the ACE1-seeded LFSR stepped per event; end_ts - start_ts == delta.
- en=0 for 50 cycles mid-run -> no new pending events, timers resume from frozen values, and the queued event still drains.
- Assert rst asynchronously while out_valid=1 -> out_valid drops immediately, pending cleared, next event id=1 with start = PERIOD_CYCLES-1 after release.
- Force id_cnt near 2^ID_W-1 and cnt near 2^TS_W-1000 -> out_id wraps to 0, and out_end_ts wraps mod 2^TS_W without error.
